// File: rtl/core_pkg.sv
// Shared types for the RV32I core pipeline.
//   result_src_t : writeback result select (ALU, memory load, PC+4)
//   mem_fsm_t    : data-memory access controller states
package core_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        REQ      = 2'b01,
        WAIT_RSP = 2'b10
    } mem_fsm_t;

endpackage

// File: rtl/dmem_ctrl.sv
// Data-memory handshake controller for the M stage.
//   clk, srst_n : clock, synchronous active-low reset
//   go_i        : aligned valid load/store present in M
//   store_i     : access is a store
//   gnt_i       : memory accepted the request
//   rvalid_i    : load data valid
//   req_o       : memory request
//   stall_o     : freeze upstream pipeline registers
//   capture_o   : load data is valid this cycle, capture it into W
module dmem_ctrl
    import core_pkg::*;
(
    input  logic clk,
    input  logic srst_n,
    input  logic go_i,
    input  logic store_i,
    input  logic gnt_i,
    input  logic rvalid_i,
    output logic req_o,
    output logic stall_o,
    output logic capture_o
);

    mem_fsm_t state_q, state_d;

    always_comb begin
        state_d   = state_q;
        req_o     = 1'b0;
        stall_o   = 1'b0;
        capture_o = 1'b0;
        case (state_q)
            IDLE: begin
                req_o   = go_i;
                // A store granted on its first cycle retires without stalling.
                stall_o = go_i & ~(store_i & gnt_i);
                if (go_i) begin
                    if (!gnt_i) begin
                        state_d = REQ;
                    end else if (!store_i) begin
                        state_d = WAIT_RSP;
                    end
                end
            end
            REQ: begin
                req_o   = 1'b1;
                stall_o = ~(store_i & gnt_i);
                if (gnt_i) begin
                    state_d = store_i ? IDLE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                stall_o = ~rvalid_i;
                if (rvalid_i) begin
                    capture_o = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset abandons any outstanding access and masks the handshake.
        if (!srst_n) begin
            state_d   = IDLE;
            req_o     = 1'b0;
            stall_o   = 1'b0;
            capture_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/mux_3to1.sv
// Three-input result mux; select 2'b11 yields zero.
//   d0_i/d1_i/d2_i : data inputs selected by sel_i = 00/01/10
//   sel_i          : select
//   y_o            : selected value
module mux_3to1 #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] d0_i,
    input  logic [Width-1:0] d1_i,
    input  logic [Width-1:0] d2_i,
    input  logic [1:0]       sel_i,
    output logic [Width-1:0] y_o
);

    always_comb begin
        y_o = '0;
        case (sel_i)
            2'b00:   y_o = d0_i;
            2'b01:   y_o = d1_i;
            2'b10:   y_o = d2_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// M stage of the 5-stage RV32I pipeline: issues loads/stores over a
// req/gnt/rvalid handshake, stalls while an access is outstanding, and
// holds the MEM/WB register feeding writeback and forwarding.
//   clk, srst_n        : clock, synchronous active-low reset
//   *_m inputs         : M-stage instruction fields from the E/M register
//   dmem_*             : data-memory request/response interface
//   stall_m            : freeze F/D/E/M registers
//   misalign_m         : misaligned load/store in M (dropped as a bubble)
//   *_w outputs        : MEM/WB register contents
//   result_w           : selected writeback value
module memory_stage
    import core_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              clk,
    input  logic              srst_n,
    input  logic              valid_m,
    input  logic [DATA_W-1:0] pc_plus4_m,
    input  logic [REG_W-1:0]  rd_m,
    input  logic [DATA_W-1:0] alu_result_m,
    input  logic [DATA_W-1:0] write_data_m,
    input  logic [1:0]        result_src_m,
    input  logic              mem_write_m,
    input  logic              reg_write_m,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall_m,
    output logic              misalign_m,
    output logic [REG_W-1:0]  rd_w,
    output logic              reg_write_w,
    output logic [1:0]        result_src_w,
    output logic [DATA_W-1:0] alu_result_w,
    output logic [DATA_W-1:0] read_data_w,
    output logic [DATA_W-1:0] pc_plus4_w,
    output logic [DATA_W-1:0] result_w
);

    logic access, misalign, go, capture;

    assign access     = valid_m & (mem_write_m | (result_src_m == RES_MEM));
    assign misalign   = access & (alu_result_m[1:0] != 2'b00);
    assign go         = access & ~misalign;
    assign misalign_m = misalign;

    // Held stable across a stall because the E/M register is frozen.
    assign dmem_addr  = alu_result_m[ADDR_W-1:0];
    assign dmem_wdata = write_data_m;
    assign dmem_we    = mem_write_m;

    dmem_ctrl u_dmem_ctrl (
        .clk       (clk),
        .srst_n    (srst_n),
        .go_i      (go),
        .store_i   (mem_write_m),
        .gnt_i     (dmem_gnt),
        .rvalid_i  (dmem_rvalid),
        .req_o     (dmem_req),
        .stall_o   (stall_m),
        .capture_o (capture)
    );

    logic [REG_W-1:0]  rd_q;
    logic              reg_write_q;
    logic [1:0]        result_src_q;
    logic [DATA_W-1:0] alu_result_q, read_data_q, pc_plus4_q;

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            result_src_q <= '0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            pc_plus4_q   <= '0;
        end else begin
            if (!stall_m) begin
                rd_q         <= rd_m;
                reg_write_q  <= reg_write_m & valid_m & ~misalign;
                result_src_q <= result_src_m;
                alu_result_q <= alu_result_m;
                pc_plus4_q   <= pc_plus4_m;
            end else begin
                // Stalled: inject a bubble, other fields simply hold.
                reg_write_q <= 1'b0;
            end
            if (capture) begin
                read_data_q <= dmem_rdata;
            end
        end
    end

    assign rd_w         = rd_q;
    assign reg_write_w  = reg_write_q;
    assign result_src_w = result_src_q;
    assign alu_result_w = alu_result_q;
    assign read_data_w  = read_data_q;
    assign pc_plus4_w   = pc_plus4_q;

    mux_3to1 #(
        .Width (DATA_W)
    ) u_result_mux (
        .d0_i  (alu_result_q),
        .d1_i  (read_data_q),
        .d2_i  (pc_plus4_q),
        .sel_i (result_src_q),
        .y_o   (result_w)
    );

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        srst_n;
    logic        valid_m;
    logic [31:0] pc_plus4_m;
    logic [4:0]  rd_m;
    logic [31:0] alu_result_m;
    logic [31:0] write_data_m;
    logic [1:0]  result_src_m;
    logic        mem_write_m;
    logic        reg_write_m;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_m;
    logic        misalign_m;
    logic [4:0]  rd_w;
    logic        reg_write_w;
    logic [1:0]  result_src_w;
    logic [31:0] alu_result_w;
    logic [31:0] read_data_w;
    logic [31:0] pc_plus4_w;
    logic [31:0] result_w;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk          (clk),
        .srst_n       (srst_n),
        .valid_m      (valid_m),
        .pc_plus4_m   (pc_plus4_m),
        .rd_m         (rd_m),
        .alu_result_m (alu_result_m),
        .write_data_m (write_data_m),
        .result_src_m (result_src_m),
        .mem_write_m  (mem_write_m),
        .reg_write_m  (reg_write_m),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .stall_m      (stall_m),
        .misalign_m   (misalign_m),
        .rd_w         (rd_w),
        .reg_write_w  (reg_write_w),
        .result_src_w (result_src_w),
        .alu_result_w (alu_result_w),
        .read_data_w  (read_data_w),
        .pc_plus4_w   (pc_plus4_w),
        .result_w     (result_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bubble();
        valid_m      = 1'b0;
        pc_plus4_m   = '0;
        rd_m         = '0;
        alu_result_m = '0;
        write_data_m = '0;
        result_src_m = 2'b00;
        mem_write_m  = 1'b0;
        reg_write_m  = 1'b0;
    endtask

    task automatic check_w_zero(input string tag);
        chk({tag, "_rd_w"}, 32'(rd_w), 32'd0);
        chk({tag, "_reg_write_w"}, 32'(reg_write_w), 32'd0);
        chk({tag, "_result_src_w"}, 32'(result_src_w), 32'd0);
        chk({tag, "_alu_result_w"}, alu_result_w, 32'd0);
        chk({tag, "_read_data_w"}, read_data_w, 32'd0);
        chk({tag, "_pc_plus4_w"}, pc_plus4_w, 32'd0);
        chk({tag, "_result_w"}, result_w, 32'd0);
    endtask

    initial begin
        srst_n      = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        bubble();
        tick();
        tick();
        #1;
        check_w_zero("reset");
        chk("reset_req", 32'(dmem_req), 32'd0);
        chk("reset_stall", 32'(stall_m), 32'd0);
        srst_n = 1'b1;

        // ALU op
        valid_m = 1'b1; result_src_m = 2'b00; alu_result_m = 32'h10; rd_m = 5'd5;
        reg_write_m = 1'b1; pc_plus4_m = 32'h4;
        #1;
        chk("alu_req", 32'(dmem_req), 32'd0);
        chk("alu_stall", 32'(stall_m), 32'd0);
        tick();
        chk("alu_rd_w", 32'(rd_w), 32'd5);
        chk("alu_reg_write_w", 32'(reg_write_w), 32'd1);
        chk("alu_result_w", result_w, 32'h10);

        // Store with immediate grant
        bubble();
        valid_m = 1'b1; mem_write_m = 1'b1; alu_result_m = 32'h100;
        write_data_m = 32'hDEADBEEF; dmem_gnt = 1'b1;
        #1;
        chk("st_req", 32'(dmem_req), 32'd1);
        chk("st_we", 32'(dmem_we), 32'd1);
        chk("st_addr", dmem_addr, 32'h100);
        chk("st_wdata", dmem_wdata, 32'hDEADBEEF);
        chk("st_stall", 32'(stall_m), 32'd0);
        tick();
        chk("st_reg_write_w", 32'(reg_write_w), 32'd0);

        // Load: gnt in cycle 0, rvalid in cycle 2
        bubble();
        valid_m = 1'b1; result_src_m = 2'b01; alu_result_m = 32'h200; rd_m = 5'd7;
        reg_write_m = 1'b1; dmem_gnt = 1'b1;
        #1;
        chk("ld_c0_req", 32'(dmem_req), 32'd1);
        chk("ld_c0_we", 32'(dmem_we), 32'd0);
        chk("ld_c0_stall", 32'(stall_m), 32'd1);
        tick();
        dmem_gnt = 1'b0;
        #1;
        chk("ld_c1_stall", 32'(stall_m), 32'd1);
        chk("ld_c1_req", 32'(dmem_req), 32'd0);
        chk("ld_c1_reg_write_w", 32'(reg_write_w), 32'd0);
        tick();
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
        #1;
        chk("ld_c2_stall", 32'(stall_m), 32'd0);
        chk("ld_c2_reg_write_w", 32'(reg_write_w), 32'd0);
        tick();
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        bubble();
        chk("ld_c3_rd_w", 32'(rd_w), 32'd7);
        chk("ld_c3_reg_write_w", 32'(reg_write_w), 32'd1);
        chk("ld_c3_result_w", result_w, 32'hCAFEF00D);
        tick();
        chk("ld_c4_reg_write_w", 32'(reg_write_w), 32'd0);

        // Store with grant delayed 3 cycles
        valid_m = 1'b1; mem_write_m = 1'b1; alu_result_m = 32'h300;
        write_data_m = 32'h12345678;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("dst_c%0d_req", c), 32'(dmem_req), 32'd1);
            chk($sformatf("dst_c%0d_stall", c), 32'(stall_m), 32'd1);
            chk($sformatf("dst_c%0d_addr", c), dmem_addr, 32'h300);
            chk($sformatf("dst_c%0d_wdata", c), dmem_wdata, 32'h12345678);
            tick();
        end
        dmem_gnt = 1'b1;
        #1;
        chk("dst_c3_req", 32'(dmem_req), 32'd1);
        chk("dst_c3_stall", 32'(stall_m), 32'd0);
        tick();
        dmem_gnt = 1'b0;
        bubble();
        #1;
        chk("dst_after_req", 32'(dmem_req), 32'd0);
        chk("dst_after_stall", 32'(stall_m), 32'd0);

        // Misaligned load
        valid_m = 1'b1; result_src_m = 2'b01; alu_result_m = 32'h102; rd_m = 5'd9;
        reg_write_m = 1'b1; dmem_gnt = 1'b1;
        #1;
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_flag", 32'(misalign_m), 32'd1);
        chk("mis_stall", 32'(stall_m), 32'd0);
        tick();
        dmem_gnt = 1'b0;
        chk("mis_reg_write_w", 32'(reg_write_w), 32'd0);

        // JAL: PC+4 writeback
        bubble();
        valid_m = 1'b1; result_src_m = 2'b10; pc_plus4_m = 32'h24; alu_result_m = 32'h55;
        rd_m = 5'd1; reg_write_m = 1'b1;
        #1;
        chk("jal_misalign", 32'(misalign_m), 32'd0);
        tick();
        chk("jal_result_w", result_w, 32'h24);
        chk("jal_reg_write_w", 32'(reg_write_w), 32'd1);

        // Select 11 yields zero
        result_src_m = 2'b11; alu_result_m = 32'h77; pc_plus4_m = 32'h88;
        tick();
        chk("sel11_result_w", result_w, 32'd0);

        // Reset during WAIT_RSP; stale rvalid afterwards is ignored
        bubble();
        valid_m = 1'b1; result_src_m = 2'b01; alu_result_m = 32'h400; rd_m = 5'd3;
        reg_write_m = 1'b1; dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        #1;
        chk("rst_wait_stall", 32'(stall_m), 32'd1);
        srst_n = 1'b0;
        #1;
        chk("rst_active_stall", 32'(stall_m), 32'd0);
        chk("rst_active_req", 32'(dmem_req), 32'd0);
        tick();
        srst_n = 1'b1;
        bubble();
        dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD0BAD;
        #1;
        check_w_zero("rst_release");
        chk("rst_release_stall", 32'(stall_m), 32'd0);
        chk("rst_release_req", 32'(dmem_req), 32'd0);
        tick();
        dmem_rvalid = 1'b0; dmem_rdata = '0;
        chk("rst_stale_read_data_w", read_data_w, 32'd0);
        chk("rst_stale_reg_write_w", 32'(reg_write_w), 32'd0);
        chk("rst_stale_stall", 32'(stall_m), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
